vga_sync_decoder: RTL and testbench

Receive-side counterpart of the team's VGA timing generator: samples the 1-bit HS/VS/R/G/B stream in the `clk_20M` domain and recovers pixel coordinates and colour. It measures line length and frame height, and declares lock only after a clean, consistent frame. It is used as a loop-back checker and capture front-end for the 2048 display path, driving a frame comparator or capture buffer downstream.

---
 rtl/vga_sync_decoder.sv | 181 ++++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates, colour and line/frame geometry from a 1-bit VGA HS/VS/RGB stream.
// Two-register latency (input sample + output stage); no backpressure, one sample per clk_20M.
module vga_sync_decoder #(
    parameter int H_ACTIVE = 640,
    parameter int H_BP     = 1,
    parameter int V_ACTIVE = 480,
    parameter int V_BP     = 1
) (
    input  logic        clk_20M,
    input  logic        rst,
    input  logic        VGA_HS,
    input  logic        VGA_VS,
    input  logic        VGA_R,
    input  logic        VGA_G,
    input  logic        VGA_B,
    output logic        pix_valid,
    output logic [10:0] pix_x,
    output logic [10:0] pix_y,
    output logic [2:0]  pix_rgb,
    output logic        frame_start,
    output logic [10:0] line_len,
    output logic [10:0] frame_lines,
    output logic        locked,
    output logic        hs_err,
    output logic        vs_err
);
    typedef enum logic [1:0] {ST_SEARCH, ST_TRACK, ST_LOCKED} state_t;

    localparam logic [10:0] LP_H_LO = 11'(H_BP);
    localparam logic [10:0] LP_H_HI = 11'(H_BP + H_ACTIVE);
    localparam logic [10:0] LP_V_LO = 11'(V_BP);
    localparam logic [10:0] LP_V_HI = 11'(V_BP + V_ACTIVE);
    localparam logic [10:0] LP_SAT  = 11'h7FF;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_hs, r_vs, r_hs_d, r_vs_d;
    logic [2:0]  r_rgb;
    logic [10:0] r_h_phase, r_v_line, r_line_len, r_frame_lines;
    logic        r_len_seen;
    logic        r_pix_valid, r_frame_start, r_hs_err, r_vs_err;
    logic [10:0] r_pix_x, r_pix_y;
    logic [2:0]  r_pix_rgb;

    logic        w_hs_fall, w_vs_fall, w_timeout, w_line_start;
    logic        w_len_bad, w_lines_bad, w_active;
    logic        w_len_ld, w_lines_ld, w_len_seen_nxt, w_hs_err, w_vs_err;
    logic [10:0] w_h_phase, w_v_line, w_pix_x, w_pix_y;
    logic [11:0] w_meas_len, w_meas_lines;

    always_comb begin
        w_hs_fall = ~r_hs & r_hs_d;
        w_vs_fall = ~r_vs & r_vs_d;
        if (w_hs_fall)
            w_h_phase = '0;
        else if (r_h_phase == LP_SAT)
            w_h_phase = LP_SAT;
        else
            w_h_phase = r_h_phase + 11'd1;
        // Timeout fires only on the step into saturation, so it pulses once.
        w_timeout    = ~w_hs_fall && (r_h_phase == LP_SAT - 11'd1);
        w_line_start = (w_h_phase == LP_H_LO);
        if (w_vs_fall)
            w_v_line = '0;
        else if (w_line_start && (r_v_line != LP_SAT))
            w_v_line = r_v_line + 11'd1;
        else
            w_v_line = r_v_line;
        w_meas_len   = {1'b0, r_h_phase} + 12'd1;
        w_meas_lines = {1'b0, r_v_line} + 12'd1;
        w_len_bad    = w_hs_fall && (w_meas_len != {1'b0, r_line_len});
        w_lines_bad  = w_vs_fall && (w_meas_lines != {1'b0, r_frame_lines});
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_len_seen_nxt = r_len_seen;
        w_len_ld       = 1'b0;
        w_lines_ld     = 1'b0;
        w_hs_err       = 1'b0;
        w_vs_err       = 1'b0;
        case (r_state)
            ST_SEARCH: begin
                if (w_vs_fall) begin
                    w_state_nxt    = ST_TRACK;
                    w_len_seen_nxt = 1'b0;
                end
            end
            ST_TRACK: begin
                if (w_timeout || (w_hs_fall && w_meas_len[11]) || (w_len_bad && r_len_seen)) begin
                    w_state_nxt = ST_SEARCH;
                end else begin
                    if (w_hs_fall) begin
                        w_len_ld       = 1'b1;
                        w_len_seen_nxt = 1'b1;
                    end
                    // A frame without any measured line is not a basis for lock.
                    if (w_vs_fall && r_len_seen) begin
                        w_lines_ld  = 1'b1;
                        w_state_nxt = ST_LOCKED;
                    end
                end
            end
            ST_LOCKED: begin
                w_hs_err = w_timeout || w_len_bad;
                w_vs_err = w_lines_bad;
                if (w_hs_err || w_vs_err)
                    w_state_nxt = ST_SEARCH;
            end
            default: w_state_nxt = ST_SEARCH;
        endcase
    end

    always_comb begin
        w_active = (w_state_nxt == ST_LOCKED) &&
                   (w_h_phase >= LP_H_LO) && (w_h_phase < LP_H_HI) &&
                   (w_v_line >= LP_V_LO) && (w_v_line < LP_V_HI);
        w_pix_x  = w_h_phase - LP_H_LO;
        w_pix_y  = w_v_line - LP_V_LO;
    end

    always_ff @(posedge clk_20M or posedge rst) begin
        if (rst)
            r_state <= ST_SEARCH;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk_20M or posedge rst) begin
        if (rst) begin
            r_hs          <= 1'b0;
            r_vs          <= 1'b0;
            r_hs_d        <= 1'b0;
            r_vs_d        <= 1'b0;
            r_rgb         <= '0;
            r_h_phase     <= LP_SAT;
            r_v_line      <= '0;
            r_line_len    <= '0;
            r_frame_lines <= '0;
            r_len_seen    <= 1'b0;
            r_pix_valid   <= 1'b0;
            r_pix_x       <= '0;
            r_pix_y       <= '0;
            r_pix_rgb     <= '0;
            r_frame_start <= 1'b0;
            r_hs_err      <= 1'b0;
            r_vs_err      <= 1'b0;
        end else begin
            r_hs          <= VGA_HS;
            r_vs          <= VGA_VS;
            r_rgb         <= {VGA_R, VGA_G, VGA_B};
            r_hs_d        <= r_hs;
            r_vs_d        <= r_vs;
            r_h_phase     <= w_h_phase;
            r_v_line      <= w_v_line;
            r_len_seen    <= w_len_seen_nxt;
            if (w_len_ld)
                r_line_len <= w_meas_len[10:0];
            if (w_lines_ld)
                r_frame_lines <= w_meas_lines[10:0];
            r_pix_valid   <= w_active;
            r_pix_x       <= w_active ? w_pix_x : 11'd0;
            r_pix_y       <= w_active ? w_pix_y : 11'd0;
            r_pix_rgb     <= w_active ? r_rgb : 3'd0;
            r_frame_start <= w_active && (w_pix_x == 11'd0) && (w_pix_y == 11'd0);
            r_hs_err      <= w_hs_err;
            r_vs_err      <= w_vs_err;
        end
    end

    assign pix_valid   = r_pix_valid;
    assign pix_x       = r_pix_x;
    assign pix_y       = r_pix_y;
    assign pix_rgb     = r_pix_rgb;
    assign frame_start = r_frame_start;
    assign line_len    = r_line_len;
    assign frame_lines = r_frame_lines;
    assign locked      = (r_state == ST_LOCKED);
    assign hs_err      = r_hs_err;
    assign vs_err      = r_vs_err;
endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder: colour bars, lock/relock, short line, HS stall, short frame, mid-frame reset.
module tb_vga_sync_decoder;
    localparam int H_ACT       = 320;
    localparam int V_ACT       = 4;
    localparam int LINE        = H_ACT + 6;
    localparam int FRAME       = V_ACT + 6;
    localparam int STUCK_TICKS = 2100;

    logic        clk_20M = 1'b0;
    logic        rst;
    logic        VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B;
    logic        pix_valid, frame_start, locked, hs_err, vs_err;
    logic [10:0] pix_x, pix_y, line_len, frame_lines;
    logic [2:0]  pix_rgb;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_valid, n_fs, n_hs_err, n_vs_err, n_locked_cyc, n_valid_post;
    int hs_err_cyc, vs_err_cyc, lock_cyc = -1;
    int vsfall_cyc, err_ref_cyc;
    logic [10:0] fs_x, fs_y;
    logic [2:0]  fs_rgb, rgb150, rgb250;
    logic        prev_locked = 1'b0;

    vga_sync_decoder #(.H_ACTIVE(H_ACT), .H_BP(1), .V_ACTIVE(V_ACT), .V_BP(1)) dut (
        .clk_20M(clk_20M), .rst(rst),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
        .frame_start(frame_start), .line_len(line_len), .frame_lines(frame_lines),
        .locked(locked), .hs_err(hs_err), .vs_err(vs_err)
    );

    always #25 clk_20M = ~clk_20M;

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        n_valid = 0; n_fs = 0; n_hs_err = 0; n_vs_err = 0; n_locked_cyc = 0; n_valid_post = 0;
        hs_err_cyc = -1; vs_err_cyc = -1;
        fs_x = 'x; fs_y = 'x; fs_rgb = 'x; rgb150 = 'x; rgb250 = 'x;
    endtask

    task automatic tick(input logic hs, input logic vs, input logic r, input logic g, input logic b);
        VGA_HS = hs; VGA_VS = vs; VGA_R = r; VGA_G = g; VGA_B = b;
        @(posedge clk_20M);
        #1;
        cyc++;
        if (hs_err) begin n_hs_err++; hs_err_cyc = cyc; end
        if (vs_err) begin n_vs_err++; vs_err_cyc = cyc; end
        if (pix_valid) n_valid++;
        if (pix_valid && n_hs_err != 0) n_valid_post++;
        if (pix_valid && pix_x == 11'd150) rgb150 = pix_rgb;
        if (pix_valid && pix_x == 11'd250) rgb250 = pix_rgb;
        if (frame_start) begin n_fs++; fs_x = pix_x; fs_y = pix_y; fs_rgb = pix_rgb; end
        if (locked && !prev_locked) lock_cyc = cyc;
        if (locked) n_locked_cyc++;
        prev_locked = locked;
    endtask

    // Generator geometry: HS high at x in [len-6, len-2], VS high at y in [n-6, n-2].
    task automatic gen_frame(input int nlines, input int short_y, input int stuck_y, input int rst_y);
        int len;
        logic [2:0] grb;
        for (int y = 0; y < nlines; y++) begin
            if (y == stuck_y) begin
                repeat (STUCK_TICKS) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                return;
            end
            len = (y == short_y) ? H_ACT : LINE;
            for (int x = 0; x < len; x++) begin
                grb = 3'b000;
                if (y < V_ACT && x < len - 6) begin
                    if (x < 100)      grb = 3'b111;
                    else if (x < 200) grb = 3'b110;
                    else if (x < 300) grb = 3'b101;
                end
                tick((x >= len - 6) && (x <= len - 2), (y >= nlines - 6) && (y <= nlines - 2),
                     grb[1], grb[2], grb[0]);
                if (y == nlines - 1 && x == 0) vsfall_cyc = cyc;
                if (x == len - 1 && (y == short_y || y == stuck_y - 1)) err_ref_cyc = cyc;
                if (y == rst_y && x == 160) begin
                    chk("pre_rst_valid", pix_valid, 1);
                    #5 rst = 1'b1;
                    #1;
                    chk("rst_async_valid", pix_valid, 0);
                    chk("rst_async_x", pix_x, 0);
                    chk("rst_async_locked", locked, 0);
                    chk("rst_async_line_len", line_len, 0);
                    chk("rst_async_frame_lines", frame_lines, 0);
                end
                if (y == rst_y && x == 163) begin
                    rst = 1'b0;
                    clr();
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        VGA_HS = 1'b0; VGA_VS = 1'b0; VGA_R = 1'b0; VGA_G = 1'b0; VGA_B = 1'b0;
        repeat (3) @(posedge clk_20M);
        #1;
        chk("reset_pix_valid", pix_valid, 0);
        chk("reset_frame_start", frame_start, 0);
        chk("reset_locked", locked, 0);
        chk("reset_hs_err", hs_err, 0);
        chk("reset_vs_err", vs_err, 0);
        chk("reset_pix_x", pix_x, 0);
        chk("reset_pix_y", pix_y, 0);
        chk("reset_pix_rgb", pix_rgb, 0);
        chk("reset_line_len", line_len, 0);
        chk("reset_frame_lines", frame_lines, 0);
        rst = 1'b0;
        clr();

        // Lock acquisition: first VS fall enters tracking, second locks.
        gen_frame(FRAME, -1, -1, -1);
        chk("unlocked_after_first_vs", locked, 0);
        chk("no_lock_cycles_frame0", n_locked_cyc, 0);
        chk("no_valid_frame0", n_valid, 0);
        gen_frame(FRAME, -1, -1, -1);
        chk("lock_rise_cycle", lock_cyc, vsfall_cyc + 1);
        chk("locked_after_second_vs", locked, 1);
        chk("line_len", line_len, LINE);
        chk("frame_lines", frame_lines, FRAME);

        // Colour bars over a full locked frame.
        clr();
        gen_frame(FRAME, -1, -1, -1);
        chk("valid_count", n_valid, H_ACT * V_ACT);
        chk("frame_start_count", n_fs, 1);
        chk("frame_start_x", fs_x, 0);
        chk("frame_start_y", fs_y, 0);
        chk("frame_start_rgb", fs_rgb, 3'b111);
        chk("rgb_at_150", rgb150, 3'b110);
        chk("rgb_at_250", rgb250, 3'b011);
        chk("no_hs_err_nominal", n_hs_err, 0);
        chk("no_vs_err_nominal", n_vs_err, 0);

        // Short line while locked.
        clr();
        gen_frame(FRAME, 2, -1, -1);
        chk("short_hs_err_count", n_hs_err, 1);
        chk("short_hs_err_cycle", hs_err_cyc, err_ref_cyc + 1);
        chk("short_unlocked", locked, 0);
        chk("short_no_valid_after", n_valid_post, 0);
        chk("short_line_len_held", line_len, LINE);
        gen_frame(FRAME, -1, -1, -1);
        chk("short_relock_cycle", lock_cyc, vsfall_cyc + 1);
        chk("short_relocked", locked, 1);
        chk("short_relock_line_len", line_len, LINE);

        // HS stuck low while locked.
        clr();
        gen_frame(FRAME, -1, 2, -1);
        chk("stuck_hs_err_count", n_hs_err, 1);
        chk("stuck_hs_err_cycle", hs_err_cyc, err_ref_cyc + 2048);
        chk("stuck_unlocked", locked, 0);
        gen_frame(FRAME, -1, -1, -1);
        gen_frame(FRAME, -1, -1, -1);
        chk("stuck_relocked", locked, 1);

        // Frame two lines short while locked.
        clr();
        gen_frame(FRAME - 2, -1, -1, -1);
        chk("short_frame_vs_err_count", n_vs_err, 1);
        chk("short_frame_vs_err_cycle", vs_err_cyc, vsfall_cyc + 1);
        chk("short_frame_lines_held", frame_lines, FRAME);
        chk("short_frame_unlocked", locked, 0);
        chk("short_frame_no_hs_err", n_hs_err, 0);
        gen_frame(FRAME, -1, -1, -1);
        chk("short_frame_tracking", locked, 0);
        gen_frame(FRAME, -1, -1, -1);
        chk("short_frame_relocked", locked, 1);
        chk("short_frame_relock_lines", frame_lines, FRAME);

        // Mid-frame asynchronous reset.
        gen_frame(FRAME, -1, -1, 2);
        chk("rst_unlocked_after_first_vs", locked, 0);
        chk("rst_no_lock_cycles", n_locked_cyc, 0);
        chk("rst_no_valid", n_valid, 0);
        gen_frame(FRAME, -1, -1, -1);
        chk("rst_relock_cycle", lock_cyc, vsfall_cyc + 1);
        chk("rst_relock_line_len", line_len, LINE);
        chk("rst_relock_frame_lines", frame_lines, FRAME);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
